// File: rtl/control_unit_pkg.sv
// Shared encodings for the ezRISC control sequencer: opcodes, ALU codes, step states,
// instruction classes and the bundled control word.
package control_unit_pkg;

   localparam logic [4:0] OpLd   = 5'b00000;
   localparam logic [4:0] OpLdi  = 5'b00001;
   localparam logic [4:0] OpSt   = 5'b00010;
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpSub  = 5'b00100;
   localparam logic [4:0] OpShr  = 5'b00101;
   localparam logic [4:0] OpShl  = 5'b00110;
   localparam logic [4:0] OpRor  = 5'b00111;
   localparam logic [4:0] OpRol  = 5'b01000;
   localparam logic [4:0] OpAnd  = 5'b01001;
   localparam logic [4:0] OpOr   = 5'b01010;
   localparam logic [4:0] OpAddi = 5'b01011;
   localparam logic [4:0] OpAndi = 5'b01100;
   localparam logic [4:0] OpOri  = 5'b01101;
   localparam logic [4:0] OpMul  = 5'b01110;
   localparam logic [4:0] OpDiv  = 5'b01111;
   localparam logic [4:0] OpNeg  = 5'b10000;
   localparam logic [4:0] OpNot  = 5'b10001;
   localparam logic [4:0] OpIn   = 5'b10101;
   localparam logic [4:0] OpOut  = 5'b10110;
   localparam logic [4:0] OpMfhi = 5'b10111;
   localparam logic [4:0] OpMflo = 5'b11000;
   localparam logic [4:0] OpNop  = 5'b11001;
   localparam logic [4:0] OpHalt = 5'b11010;

   // Same encoding the datapath ALU decodes.
   typedef enum logic [3:0] {
      AluAdd = 4'd0,  AluSub = 4'd1,  AluAnd = 4'd2,  AluOr  = 4'd3,
      AluShr = 4'd4,  AluShl = 4'd5,  AluRor = 4'd6,  AluRol = 4'd7,
      AluMul = 4'd8,  AluDiv = 4'd9,  AluNeg = 4'd10, AluNot = 4'd11
   } alu_op_e;

   typedef enum logic [3:0] {
      StT0 = 4'd0, StT1 = 4'd1, StT2 = 4'd2, StT3 = 4'd3, StT4 = 4'd4,
      StT5 = 4'd5, StT6 = 4'd6, StT7 = 4'd7, StT8 = 4'd8, StT9 = 4'd9,
      StHalt = 4'd15
   } state_e;

   typedef enum logic [3:0] {
      ClsLd, ClsLdi, ClsSt, ClsAlu, ClsAluImm, ClsMulDiv, ClsUnary,
      ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
   } op_class_e;

   typedef struct packed {
      logic    gra;
      logic    grb;
      logic    grc;
      logic    r_in;
      logic    r_out;
      logic    ba_out;
      logic    hi_in;
      logic    hi_out;
      logic    lo_in;
      logic    lo_out;
      logic    pc_in;
      logic    pc_out;
      logic    ir_in;
      logic    z_in;
      logic    z_high_out;
      logic    z_low_out;
      logic    y_in;
      logic    mar_in;
      logic    inport_out;
      logic    outport_in;
      logic    c_out;
      logic    mdr_in;
      logic    mdr_out;
      logic    read;
      logic    write;
      logic    inc_pc;
      logic    illegal_op;
      alu_op_e alu_op;
   } ctrl_t;

   function automatic op_class_e op_class(input logic [4:0] op);
      case (op)
         OpLd:                   return ClsLd;
         OpLdi:                  return ClsLdi;
         OpSt:                   return ClsSt;
         OpAdd, OpSub, OpShr, OpShl,
         OpRor, OpRol, OpAnd, OpOr: return ClsAlu;
         OpAddi, OpAndi, OpOri:  return ClsAluImm;
         OpMul, OpDiv:           return ClsMulDiv;
         OpNeg, OpNot:           return ClsUnary;
         OpIn:                   return ClsIn;
         OpOut:                  return ClsOut;
         OpMfhi:                 return ClsMfhi;
         OpMflo:                 return ClsMflo;
         OpNop:                  return ClsNop;
         OpHalt:                 return ClsHalt;
         default:                return ClsIllegal;
      endcase
   endfunction

   function automatic alu_op_e alu_of(input logic [4:0] op);
      case (op)
         OpAdd, OpAddi: return AluAdd;
         OpSub:         return AluSub;
         OpShr:         return AluShr;
         OpShl:         return AluShl;
         OpRor:         return AluRor;
         OpRol:         return AluRol;
         OpAnd, OpAndi: return AluAnd;
         OpOr, OpOri:   return AluOr;
         OpMul:         return AluMul;
         OpDiv:         return AluDiv;
         OpNeg:         return AluNeg;
         OpNot:         return AluNot;
         default:       return AluAdd;
      endcase
   endfunction

   // Final execute step of each class; the step after it is T0 (or HALT).
   function automatic state_e last_step(input op_class_e cls);
      case (cls)
         ClsLd:              return StT9;
         ClsSt:              return StT8;
         ClsMulDiv:          return StT7;
         ClsLdi, ClsAlu,
         ClsAluImm:          return StT6;
         ClsUnary:           return StT5;
         default:            return StT4;
      endcase
   endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle ezRISC control sequencer: a step-state register plus a Moore decode of
// (state, opcode) that drives every datapath control input, one bus transfer per clock.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned REG_SIZE = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_SIZE-1:0] ir,
   input  logic                stop,
   output logic                run,
   output logic                illegal_op,
   output logic                gra,
   output logic                grb,
   output logic                grc,
   output logic                r_in,
   output logic                r_out,
   output logic                ba_out,
   output logic                hi_in,
   output logic                hi_out,
   output logic                lo_in,
   output logic                lo_out,
   output logic                pc_in,
   output logic                pc_out,
   output logic                ir_in,
   output logic                z_in,
   output logic                z_high_out,
   output logic                z_low_out,
   output logic                y_in,
   output logic                mar_in,
   output logic                inport_out,
   output logic                outport_in,
   output logic                c_out,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                read,
   output logic                write,
   output logic                inc_pc,
   output logic [3:0]          alu_op
);

   logic [4:0] opcode;
   logic       unused_ir;
   op_class_e  cls;
   state_e     state_q, state_d;
   logic       stop_q;
   ctrl_t      ctrl, ctrl_out;

   assign opcode    = ir[REG_SIZE-1 -: 5];
   assign unused_ir = ^ir[REG_SIZE-6:0];
   assign cls       = op_class(opcode);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StT0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StT3) stop_q <= stop;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHalt:                 state_d = StHalt;
         StT0, StT1, StT2, StT3: state_d = state_e'(state_q + 4'd1);
         default: begin
            if (state_q == last_step(cls)) begin
               state_d = (stop_q || cls == ClsHalt) ? StHalt : StT0;
            end else begin
               state_d = state_e'(state_q + 4'd1);
            end
         end
      endcase
   end

   always_comb begin
      ctrl = '0;
      unique case (state_q)
         StT0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
            ctrl.alu_op = AluAdd;
            ctrl.z_in   = 1'b1;
         end
         StT1: begin
            ctrl.z_low_out = 1'b1;
            ctrl.pc_in     = 1'b1;
         end
         StT2: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
         end
         StT3: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         StHalt: ;
         default: begin
            unique case (cls)
               ClsLd, ClsLdi, ClsSt: begin
                  case (state_q)
                     StT4: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                     end
                     StT5: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.alu_op = AluAdd;
                        ctrl.z_in   = 1'b1;
                     end
                     StT6: begin
                        ctrl.z_low_out = 1'b1;
                        if (cls == ClsLdi) begin
                           ctrl.gra  = 1'b1;
                           ctrl.r_in = 1'b1;
                        end else begin
                           ctrl.mar_in = 1'b1;
                        end
                     end
                     // T7 of ld is an idle step covering RAM latency.
                     StT7: begin
                        if (cls == ClsSt) begin
                           ctrl.gra    = 1'b1;
                           ctrl.r_out  = 1'b1;
                           ctrl.mdr_in = 1'b1;
                        end
                     end
                     StT8: begin
                        ctrl.read   = (cls == ClsLd);
                        ctrl.mdr_in = (cls == ClsLd);
                        ctrl.write  = (cls == ClsSt);
                     end
                     StT9: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                     end
                     default: ;
                  endcase
               end
               ClsAlu, ClsAluImm: begin
                  case (state_q)
                     StT4: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                     end
                     StT5: begin
                        ctrl.alu_op = alu_of(opcode);
                        ctrl.z_in   = 1'b1;
                        ctrl.c_out  = (cls == ClsAluImm);
                        ctrl.grc    = (cls == ClsAlu);
                        ctrl.r_out  = (cls == ClsAlu);
                     end
                     StT6: begin
                        ctrl.z_low_out = 1'b1;
                        ctrl.gra       = 1'b1;
                        ctrl.r_in      = 1'b1;
                     end
                     default: ;
                  endcase
               end
               ClsMulDiv: begin
                  case (state_q)
                     StT4: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                     end
                     StT5: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.alu_op = alu_of(opcode);
                        ctrl.z_in   = 1'b1;
                     end
                     StT6: begin
                        ctrl.z_low_out = 1'b1;
                        ctrl.lo_in     = 1'b1;
                     end
                     StT7: begin
                        ctrl.z_high_out = 1'b1;
                        ctrl.hi_in      = 1'b1;
                     end
                     default: ;
                  endcase
               end
               ClsUnary: begin
                  if (state_q == StT4) begin
                     ctrl.grb    = 1'b1;
                     ctrl.r_out  = 1'b1;
                     ctrl.alu_op = alu_of(opcode);
                     ctrl.z_in   = 1'b1;
                  end else if (state_q == StT5) begin
                     ctrl.z_low_out = 1'b1;
                     ctrl.gra       = 1'b1;
                     ctrl.r_in      = 1'b1;
                  end
               end
               ClsIn: begin
                  ctrl.inport_out = (state_q == StT4);
                  ctrl.gra        = (state_q == StT4);
                  ctrl.r_in       = (state_q == StT4);
               end
               ClsOut: begin
                  ctrl.gra        = (state_q == StT4);
                  ctrl.r_out      = (state_q == StT4);
                  ctrl.outport_in = (state_q == StT4);
               end
               ClsMfhi: begin
                  ctrl.hi_out = (state_q == StT4);
                  ctrl.gra    = (state_q == StT4);
                  ctrl.r_in   = (state_q == StT4);
               end
               ClsMflo: begin
                  ctrl.lo_out = (state_q == StT4);
                  ctrl.gra    = (state_q == StT4);
                  ctrl.r_in   = (state_q == StT4);
               end
               ClsIllegal: ctrl.illegal_op = (state_q == StT4);
               default: ;
            endcase
         end
      endcase
   end

   // Outputs act on the edge that ends the step, so holding them low while reset is high
   // keeps an aborted instruction from landing a partial register or memory write.
   assign ctrl_out = reset ? '0 : ctrl;

   assign run        = (state_q != StHalt);
   assign illegal_op = ctrl_out.illegal_op;
   assign gra        = ctrl_out.gra;
   assign grb        = ctrl_out.grb;
   assign grc        = ctrl_out.grc;
   assign r_in       = ctrl_out.r_in;
   assign r_out      = ctrl_out.r_out;
   assign ba_out     = ctrl_out.ba_out;
   assign hi_in      = ctrl_out.hi_in;
   assign hi_out     = ctrl_out.hi_out;
   assign lo_in      = ctrl_out.lo_in;
   assign lo_out     = ctrl_out.lo_out;
   assign pc_in      = ctrl_out.pc_in;
   assign pc_out     = ctrl_out.pc_out;
   assign ir_in      = ctrl_out.ir_in;
   assign z_in       = ctrl_out.z_in;
   assign z_high_out = ctrl_out.z_high_out;
   assign z_low_out  = ctrl_out.z_low_out;
   assign y_in       = ctrl_out.y_in;
   assign mar_in     = ctrl_out.mar_in;
   assign inport_out = ctrl_out.inport_out;
   assign outport_in = ctrl_out.outport_in;
   assign c_out      = ctrl_out.c_out;
   assign mdr_in     = ctrl_out.mdr_in;
   assign mdr_out    = ctrl_out.mdr_out;
   assign read       = ctrl_out.read;
   assign write      = ctrl_out.write;
   assign inc_pc     = ctrl_out.inc_pc;
   assign alu_op     = ctrl_out.alu_op;

endmodule
